// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit bimodal counters: zero-latency IF lookup,
// EX-stage resolve/update, mispredict redirect and saturating perf counters.
module bpu_btb #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned TAG_W     = 8,
  parameter int unsigned PRED_MODE = 1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [31:0]      i_if_pc,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_target,
  input  logic             i_upd_vld,
  input  logic [31:0]      i_upd_pc,
  input  logic             i_upd_is_jmp,
  input  logic             i_upd_taken,
  input  logic [31:0]      i_upd_target,
  input  logic             i_upd_pred_taken,
  input  logic [31:0]      i_upd_pred_target,
  input  logic [31:0]      i_upd_pcplus4,
  output logic             o_mispredict,
  output logic [31:0]      o_redirect_pc,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mis_cnt
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [TAG_W-1:0] tag_d [DEPTH];
  logic [31:0]      tgt_q [DEPTH];
  logic [31:0]      tgt_d [DEPTH];
  logic [1:0]       ctr_q [DEPTH];
  logic [1:0]       ctr_d [DEPTH];
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;

  logic [IDX_W-1:0] lk_idx, upd_idx;
  logic [TAG_W-1:0] lk_tag, upd_tag;
  logic             lk_hit, upd_hit, mispredict_c;
  logic             unused_pc_bits;

  assign lk_idx  = i_if_pc[IDX_W+1:2];
  assign lk_tag  = i_if_pc[IDX_W+2 +: TAG_W];
  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[IDX_W+2 +: TAG_W];
  assign unused_pc_bits = ^{i_if_pc, i_upd_pc};

  assign lk_hit  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  // Lookup reads the pre-update entry; writes become visible next cycle.
  assign o_pred_taken  = (PRED_MODE != 0) && !i_rst && lk_hit && ctr_q[lk_idx][1];
  assign o_pred_target = o_pred_taken ? tgt_q[lk_idx] : 32'd0;

  assign mispredict_c  = i_upd_vld &&
                         ((i_upd_taken != i_upd_pred_taken) ||
                          (i_upd_taken && (i_upd_target != i_upd_pred_target)));
  assign o_mispredict  = mispredict_c;
  assign o_redirect_pc = !mispredict_c ? 32'd0 :
                         (i_upd_taken ? i_upd_target : i_upd_pcplus4);

  assign o_br_cnt  = br_cnt_q;
  assign o_mis_cnt = mis_cnt_q;

  // Table update from the resolved instruction.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    ctr_d   = ctr_q;
    if ((PRED_MODE != 0) && i_upd_vld) begin
      if (upd_hit) begin
        if (i_upd_is_jmp) begin
          ctr_d[upd_idx] = 2'd3;
          tgt_d[upd_idx] = i_upd_target;
        end else if (i_upd_taken) begin
          if (ctr_q[upd_idx] != 2'd3) ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
          tgt_d[upd_idx] = i_upd_target;
        end else if (ctr_q[upd_idx] != 2'd0) begin
          ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
        end
      end else if (i_upd_taken) begin
        valid_d[upd_idx] = 1'b1;
        tag_d[upd_idx]   = upd_tag;
        tgt_d[upd_idx]   = i_upd_target;
        ctr_d[upd_idx]   = i_upd_is_jmp ? 2'd3 : 2'd2;
      end
    end
  end

  // Saturating performance counters.
  always_comb begin
    br_cnt_d  = br_cnt_q;
    mis_cnt_d = mis_cnt_q;
    if (i_upd_vld && (br_cnt_q != {CNT_W{1'b1}})) br_cnt_d = br_cnt_q + CNT_W'(1);
    if (mispredict_c && (mis_cnt_q != {CNT_W{1'b1}})) mis_cnt_d = mis_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q   <= '0;
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= 32'd0;
        ctr_q[i] <= 2'b01;
      end
    end else begin
      valid_q   <= valid_d;
      tag_q     <= tag_d;
      tgt_q     <= tgt_d;
      ctr_q     <= ctr_d;
      br_cnt_q  <= br_cnt_d;
      mis_cnt_q <= mis_cnt_d;
    end
  end

endmodule

// File: tb/tb_bpu_btb.sv
// Randomized bench for bpu_btb against a table/count reference model; a
// second instance checks static mode and narrow-counter saturation.
module tb_bpu_btb;

  logic        i_clk, i_rst;
  logic [31:0] i_if_pc, i_upd_pc, i_upd_target, i_upd_pred_target, i_upd_pcplus4;
  logic        i_upd_vld, i_upd_is_jmp, i_upd_taken, i_upd_pred_taken;

  logic        pt1, mis1, pt0, mis0;
  logic [31:0] ptgt1, redir1, ptgt0, redir0, br1, mc1;
  logic [3:0]  br0, mc0;

  int n_vec = 0;
  int n_err = 0;

  bpu_btb dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_if_pc(i_if_pc),
    .o_pred_taken(pt1), .o_pred_target(ptgt1),
    .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_is_jmp(i_upd_is_jmp),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
    .i_upd_pred_taken(i_upd_pred_taken), .i_upd_pred_target(i_upd_pred_target),
    .i_upd_pcplus4(i_upd_pcplus4), .o_mispredict(mis1), .o_redirect_pc(redir1),
    .o_br_cnt(br1), .o_mis_cnt(mc1)
  );

  bpu_btb #(.PRED_MODE(0), .CNT_W(4)) dut0 (
    .i_clk(i_clk), .i_rst(i_rst), .i_if_pc(i_if_pc),
    .o_pred_taken(pt0), .o_pred_target(ptgt0),
    .i_upd_vld(i_upd_vld), .i_upd_pc(i_upd_pc), .i_upd_is_jmp(i_upd_is_jmp),
    .i_upd_taken(i_upd_taken), .i_upd_target(i_upd_target),
    .i_upd_pred_taken(i_upd_pred_taken), .i_upd_pred_target(i_upd_pred_target),
    .i_upd_pcplus4(i_upd_pcplus4), .o_mispredict(mis0), .o_redirect_pc(redir0),
    .o_br_cnt(br0), .o_mis_cnt(mc0)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: 16 entries, tag = pc[13:6], counter value 0..3.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  longint      m_br, m_mis;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  function automatic int unsigned mtag(input logic [31:0] pc);
    return int'((pc >> 6) % 256);
  endfunction

  function automatic bit mpred(input logic [31:0] pc);
    int i;
    i = midx(pc);
    return m_valid[i] && (m_tag[i] == mtag(pc)) && (m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] mpred_tgt(input logic [31:0] pc);
    return mpred(pc) ? m_tgt[midx(pc)] : 32'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 32'd0; m_ctr[i] = 1;
    end
    m_br = 0; m_mis = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_counts();
    chk("br_cnt", br1, 32'(m_br));
    chk("mis_cnt", mc1, 32'(m_mis));
    chk("br_cnt_w4", 32'(br0), 32'((m_br > 15) ? 15 : m_br));
    chk("mis_cnt_w4", 32'(mc0), 32'((m_mis > 15) ? 15 : m_mis));
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check counts.
  task automatic step(input logic [31:0] if_pc, input logic vld, input logic [31:0] upc,
                      input logic jmp, input logic tk, input logic [31:0] tgt,
                      input logic ptk, input logic [31:0] ptgt);
    bit          emis, hit;
    logic [31:0] eredir;
    int          ui;
    @(negedge i_clk);
    i_if_pc = if_pc; i_upd_vld = vld; i_upd_pc = upc; i_upd_is_jmp = jmp;
    i_upd_taken = tk; i_upd_target = tgt; i_upd_pred_taken = ptk;
    i_upd_pred_target = ptgt; i_upd_pcplus4 = upc + 32'd4;
    #1;
    emis   = vld && ((tk != ptk) || (tk && (tgt != ptgt)));
    eredir = !emis ? 32'd0 : (tk ? tgt : upc + 32'd4);
    chk("pred_taken", 32'(pt1), 32'(mpred(if_pc)));
    chk("pred_target", ptgt1, mpred_tgt(if_pc));
    chk("mispredict", 32'(mis1), 32'(emis));
    chk("redirect_pc", redir1, eredir);
    chk("static_pred_taken", 32'(pt0), 32'd0);
    chk("static_pred_target", ptgt0, 32'd0);
    chk("static_mispredict", 32'(mis0), 32'(emis));
    @(posedge i_clk);
    #1;
    if (vld) begin
      m_br++;
      if (emis) m_mis++;
      ui  = midx(upc);
      hit = m_valid[ui] && (m_tag[ui] == mtag(upc));
      if (hit && jmp) begin
        m_ctr[ui] = 3; m_tgt[ui] = tgt;
      end else if (hit && tk) begin
        m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3; m_tgt[ui] = tgt;
      end else if (hit) begin
        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
      end else if (tk) begin
        m_valid[ui] = 1; m_tag[ui] = mtag(upc); m_tgt[ui] = tgt; m_ctr[ui] = jmp ? 3 : 2;
      end
    end
    chk_counts();
  endtask

  task automatic idle(input logic [31:0] if_pc);
    step(if_pc, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] upc, lpc, tgt, ptgt;
    logic        jmp, tk, ptk, vld;

    i_rst = 1'b1; i_if_pc = 32'd0; i_upd_vld = 1'b0; i_upd_pc = 32'd0;
    i_upd_is_jmp = 1'b0; i_upd_taken = 1'b0; i_upd_target = 32'd0;
    i_upd_pred_taken = 1'b0; i_upd_pred_target = 32'd0; i_upd_pcplus4 = 32'd0;
    model_reset();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;

    // Reset state and the first allocation.
    idle(32'h40);
    step(32'h40, 1, 32'h40, 0, 1, 32'h100, 0, 32'h0);
    chk("alloc_mis_cnt", mc1, 32'd1);
    idle(32'h40);
    chk("alloc_pred_target", ptgt1, 32'h100);
    // Counter walks down, then one taken from strongly-not-taken.
    step(32'h40, 1, 32'h40, 0, 0, 32'h0, 1, 32'h100);
    step(32'h40, 1, 32'h40, 0, 0, 32'h0, 0, 32'h0);
    step(32'h40, 1, 32'h40, 0, 1, 32'h100, 0, 32'h0);
    chk("weak_nt_no_pred", 32'(pt1), 32'd0);
    // Jump then aliasing branch at same index, different tag.
    step(32'h80, 1, 32'h80, 1, 1, 32'h200, 0, 32'h0);
    idle(32'h80);
    step(32'hC0, 1, 32'hC0, 0, 1, 32'h300, 0, 32'h0);
    idle(32'h80);
    idle(32'hC0);
    chk("alias_pred_target", ptgt1, 32'h300);
    // Same-cycle lookup/update, and a not-taken mispredict redirect.
    step(32'h40, 1, 32'h40, 1, 1, 32'h180, 0, 32'h0);
    step(32'h40, 1, 32'h40, 0, 1, 32'h240, 1, 32'h180);
    idle(32'h40);
    step(32'h40, 1, 32'h40, 0, 0, 32'h0, 1, 32'h240);
    chk("nt_redirect", redir1, 32'h44);

    // Randomized traffic over a small aliasing PC space.
    for (int n = 0; n < 300; n++) begin
      upc  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
             (32'($urandom_range(0, 1)) << 20);
      lpc  = ($urandom_range(0, 1) == 1) ? upc :
             ((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2));
      vld  = ($urandom_range(0, 3) != 0);
      jmp  = ($urandom_range(0, 3) == 0);
      tk   = jmp ? 1'b1 : 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: tgt = 32'h100;
        1: tgt = 32'h200;
        2: tgt = 32'h300;
        default: tgt = $urandom & 32'hFFFF_FFFC;
      endcase
      if ($urandom_range(0, 1) == 1) begin
        ptk = mpred(upc); ptgt = mpred_tgt(upc);
      end else begin
        ptk = 1'($urandom_range(0, 1)); ptgt = ptk ? tgt : 32'd0;
      end
      step(lpc, vld, upc, jmp, tk, tgt, ptk, ptgt);
    end

    // Asynchronous reset in the middle of an update.
    step(32'h40, 1, 32'h40, 1, 1, 32'h500, 0, 32'h0);
    @(negedge i_clk);
    i_if_pc = 32'h40; i_upd_vld = 1'b1; i_upd_pc = 32'h40; i_upd_is_jmp = 1'b1;
    i_upd_taken = 1'b1; i_upd_target = 32'h600; i_upd_pred_taken = 1'b0;
    i_upd_pred_target = 32'h0; i_upd_pcplus4 = 32'h44;
    #1;
    chk("pre_rst_pred_taken", 32'(pt1), 32'd1);
    #1;
    i_rst = 1'b1;
    #1;
    chk("rst_pred_taken", 32'(pt1), 32'd0);
    chk("rst_pred_target", ptgt1, 32'd0);
    chk("rst_br_cnt", br1, 32'd0);
    chk("rst_mis_cnt", mc1, 32'd0);
    chk("rst_mispredict", 32'(mis1), 32'd1);
    chk("rst_redirect", redir1, 32'h600);
    @(posedge i_clk);
    #1;
    chk("rst_hold_br_cnt", br1, 32'd0);
    chk("rst_hold_pred", 32'(pt1), 32'd0);
    @(negedge i_clk);
    i_upd_vld = 1'b0;
    i_rst = 1'b0;
    model_reset();
    idle(32'h40);
    idle(32'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
